// File: rtl/rgb_merge_sched_if.sv
// Channel sample inputs, merger handshake and status bundle for rgb_merge_sched.
// "master" drives samples and merger completion; "slave" is the scheduler.
interface rgb_merge_sched_if #(
  parameter int unsigned LINE_W = 640
);
  localparam int unsigned PCW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [7:0]     r_in, g_in, b_in;
  logic           r_valid, g_valid, b_valid;
  logic           r_ready, g_ready, b_ready;
  logic [7:0]     m_r, m_g, m_b;
  logic           m_valid;
  logic           m_done;
  logic           busy;
  logic           eol;
  logic [PCW-1:0] pix_cnt;
  logic           tmo_err;

  modport master (
    output r_in, g_in, b_in, r_valid, g_valid, b_valid, m_done,
    input  r_ready, g_ready, b_ready, m_r, m_g, m_b, m_valid, busy, eol, pix_cnt, tmo_err
  );

  modport slave (
    input  r_in, g_in, b_in, r_valid, g_valid, b_valid, m_done,
    output r_ready, g_ready, b_ready, m_r, m_g, m_b, m_valid, busy, eol, pix_cnt, tmo_err
  );
endinterface

// File: rtl/rgb_merge_sched.sv
// Buffers R/G/B samples in per-channel FIFOs and issues one merge at a time to a
// downstream merger, tracking pixel position within a line and merge timeouts.
module rgb_merge_sched #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned TMO    = 15
) (
  input logic              clk,
  input logic              rst,
  rgb_merge_sched_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned PCW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  logic [7:0]    mem_q [3][DEPTH];
  logic [AW-1:0] wr_q  [3];
  logic [AW-1:0] rd_q  [3];
  logic [CW-1:0] cnt_q [3];
  logic [7:0]    din   [3];
  logic [7:0]    head  [3];
  logic [2:0]    vld, rdy, push;
  logic          pop;

  state_e         state_q;
  logic [7:0]     m_r_q, m_g_q, m_b_q;
  logic           m_valid_q, busy_q, eol_q, tmo_err_q;
  logic [PCW-1:0] pix_q;
  logic [7:0]     tmo_cnt_q;

  assign din[0] = bus.r_in;
  assign din[1] = bus.g_in;
  assign din[2] = bus.b_in;
  assign vld    = {bus.b_valid, bus.g_valid, bus.r_valid};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdy[i]  = cnt_q[i] < CW'(DEPTH);
      head[i] = mem_q[i][rd_q[i]];
    end
  end

  assign push = vld & rdy;
  // All three channels pop together, only on the IDLE -> ISSUE edge.
  assign pop  = (state_q == StIdle) && (cnt_q[0] != '0) && (cnt_q[1] != '0) && (cnt_q[2] != '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
        if (pop)     rd_q[i] <= rd_q[i] + 1'b1;
        if (push[i] && !pop)      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!push[i] && pop) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      m_r_q     <= '0;
      m_g_q     <= '0;
      m_b_q     <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      eol_q     <= 1'b0;
      pix_q     <= '0;
      tmo_err_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      m_valid_q <= 1'b0;
      eol_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q   <= StIssue;
            m_r_q     <= head[0];
            m_g_q     <= head[1];
            m_b_q     <= head[2];
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StIssue: begin
          state_q   <= StWait;
          tmo_cnt_q <= '0;
        end
        StWait: begin
          if (bus.m_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (pix_q == PCW'(LINE_W - 1)) begin
              pix_q <= '0;
              eol_q <= 1'b1;
            end else begin
              pix_q <= pix_q + 1'b1;
            end
          end else if (tmo_cnt_q == 8'(TMO - 1)) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.r_ready = rdy[0];
  assign bus.g_ready = rdy[1];
  assign bus.b_ready = rdy[2];
  assign bus.m_r     = m_r_q;
  assign bus.m_g     = m_g_q;
  assign bus.m_b     = m_b_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = busy_q;
  assign bus.eol     = eol_q;
  assign bus.pix_cnt = pix_q;
  assign bus.tmo_err = tmo_err_q;
endmodule

// File: tb/tb_rgb_merge_sched.sv
// Directed bench for rgb_merge_sched with a 2-cycle merger model and a random
// in-order scoreboard phase.
module tb_rgb_merge_sched;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LINE_W = 4;
  localparam int unsigned TMO    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_merge_sched_if #(.LINE_W(LINE_W)) bus ();

  rgb_merge_sched #(.DEPTH(DEPTH), .LINE_W(LINE_W), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Merger model: data_out_valid two cycles after data_valid.
  logic merger_en = 1'b1;
  logic inj_done  = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= bus.m_valid & merger_en;
    d2 <= d1;
  end
  assign bus.m_done = d2 | inj_done;

  int          n_chk = 0;
  int          n_pass = 0;
  int          mv_cnt, busy_cyc;
  logic [23:0] got_q[$];
  int          eol_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] got_at(input int k);
    return (k < got_q.size()) ? {8'h0, got_q[k]} : 32'hdeadbeef;
  endfunction

  function automatic logic [31:0] eol_at(input int k);
    return (k < eol_q.size()) ? 32'(eol_q[k]) : 32'hdeadbeef;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (bus.m_valid) begin
      got_q.push_back({bus.m_r, bus.m_g, bus.m_b});
      mv_cnt++;
    end
    if (bus.busy) busy_cyc++;
    if (bus.eol) eol_q.push_back(mv_cnt);
  endtask

  task automatic clr_stats();
    mv_cnt   = 0;
    busy_cyc = 0;
    got_q.delete();
    eol_q.delete();
  endtask

  task automatic idle_in();
    bus.r_valid = 1'b0;
    bus.g_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // mask bit 0 = R, 1 = G, 2 = B
  task automatic push3(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [2:0] mask);
    bus.r_in = r;  bus.r_valid = mask[0];
    bus.g_in = g;  bus.g_valid = mask[1];
    bus.b_in = b;  bus.b_valid = mask[2];
    tick();
    idle_in();
  endtask

  task automatic wait_mv(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.m_valid) found = 1'b1;
    end
  endtask

  logic        found;
  int          idx, bad;
  logic        acc;
  logic [7:0]  er[$], eg[$], eb[$];
  int          sent[3];
  logic        v[3];
  logic [7:0]  d[3];
  logic [2:0]  rd;

  initial begin
    bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;
    idle_in();
    clr_stats();
    do_reset();

    // Reset state
    check("rst_ready", {29'h0, bus.b_ready, bus.g_ready, bus.r_ready}, 32'h7);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_eol", bus.eol, 0);
    check("rst_pix", bus.pix_cnt, 0);
    check("rst_tmo", bus.tmo_err, 0);
    check("rst_mrgb", {bus.m_r, bus.m_g, bus.m_b}, 0);

    // Single merge
    clr_stats();
    push3(8'h11, 8'h22, 8'h33, 3'b111);
    repeat (8) tick();
    check("one_mv_cnt", mv_cnt, 1);
    check("one_triple", got_at(0), 32'h112233);
    check("one_busy_cyc", busy_cyc, 3);
    check("one_pix", bus.pix_cnt, 1);
    check("one_mrgb_hold", {bus.m_r, bus.m_g, bus.m_b}, 32'h112233);

    // R-only fill to full, then drop while full
    clr_stats();
    for (int k = 0; k < 4; k++) begin
      bus.r_valid = 1'b1;
      bus.r_in    = 8'hA0 + 8'(k);
      tick();
    end
    bus.r_in = 8'hEE;
    tick();
    tick();
    idle_in();
    tick();
    check("full_r_ready", bus.r_ready, 0);
    check("full_g_ready", bus.g_ready, 1);
    check("full_no_mv", mv_cnt, 0);
    push3(8'h00, 8'h5A, 8'hC3, 3'b110);
    repeat (8) tick();
    check("full_mv_cnt", mv_cnt, 1);
    check("full_triple", got_at(0), 32'hA05AC3);
    check("full_r_ready_back", bus.r_ready, 1);
    check("full_pix", bus.pix_cnt, 2);
    for (int k = 0; k < 3; k++) push3(8'h00, 8'h61 + 8'(k), 8'h71 + 8'(k), 3'b110);
    repeat (16) tick();
    check("drain_mv_cnt", mv_cnt, 4);
    check("drain_triple1", got_at(1), 32'hA16171);
    check("drain_triple3", got_at(3), 32'hA36373);
    push3(8'h00, 8'h99, 8'h99, 3'b110);
    repeat (8) tick();
    check("drop_while_full", mv_cnt, 4);

    // Line wrap with LINE_W=4 over 9 merges
    do_reset();
    clr_stats();
    idx = 0;
    for (int c = 0; c < 150; c++) begin
      acc = bus.r_ready && bus.g_ready && bus.b_ready && (idx < 9);
      bus.r_valid = (idx < 9); bus.r_in = 8'h10 + 8'(idx);
      bus.g_valid = (idx < 9); bus.g_in = 8'h20 + 8'(idx);
      bus.b_valid = (idx < 9); bus.b_in = 8'h30 + 8'(idx);
      tick();
      if (acc) idx++;
    end
    idle_in();
    tick();
    check("line_mv_cnt", mv_cnt, 9);
    check("line_eol_cnt", eol_q.size(), 2);
    check("line_eol0", eol_at(0), 4);
    check("line_eol1", eol_at(1), 8);
    check("line_pix", bus.pix_cnt, 1);
    check("line_first", got_at(0), 32'h102030);
    check("line_last", got_at(8), 32'h182838);

    // Timeout
    merger_en = 1'b0;
    clr_stats();
    push3(8'h01, 8'h02, 8'h03, 3'b111);
    wait_mv(found);
    check("tmo_issue_seen", found, 1);
    repeat (15) tick();
    check("tmo_not_yet", bus.tmo_err, 0);
    check("tmo_busy_before", bus.busy, 1);
    tick();
    check("tmo_err_set", bus.tmo_err, 1);
    check("tmo_idle", bus.busy, 0);
    check("tmo_pix_kept", bus.pix_cnt, 1);
    merger_en = 1'b1;
    push3(8'h04, 8'h05, 8'h06, 3'b111);
    repeat (8) tick();
    check("tmo_sticky", bus.tmo_err, 1);
    check("tmo_next_triple", got_at(1), 32'h040506);
    check("tmo_next_pix", bus.pix_cnt, 2);

    // Reset during WAIT; late m_done ignored; FIFOs flushed
    do_reset();
    check("rst_clears_tmo", bus.tmo_err, 0);
    merger_en = 1'b0;
    clr_stats();
    push3(8'hAA, 8'hBB, 8'hCC, 3'b111);
    push3(8'hDD, 8'hEE, 8'hFF, 3'b111);
    tick();
    tick();
    check("rw_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (4) tick();
    check("rw_pix", bus.pix_cnt, 0);
    check("rw_eol_cnt", eol_q.size(), 0);
    check("rw_busy", bus.busy, 0);
    check("rw_ready", {29'h0, bus.b_ready, bus.g_ready, bus.r_ready}, 32'h7);
    check("rw_mv_cnt", mv_cnt, 1);
    push3(8'h00, 8'h12, 8'h34, 3'b110);
    repeat (6) tick();
    check("rw_r_empty", mv_cnt, 1);
    push3(8'h56, 8'h00, 8'h00, 3'b001);
    repeat (8) tick();
    check("rw_post_triple", got_at(1), 32'h561234);

    // Random streams, in-order scoreboard
    do_reset();
    merger_en = 1'b1;
    clr_stats();
    er.delete(); eg.delete(); eb.delete();
    for (int ch = 0; ch < 3; ch++) sent[ch] = 0;
    for (int c = 0; c < 12000 && mv_cnt < 1000; c++) begin
      rd = {bus.b_ready, bus.g_ready, bus.r_ready};
      for (int ch = 0; ch < 3; ch++) begin
        v[ch] = (sent[ch] < 1000) && ($urandom_range(0, 3) != 0);
        d[ch] = 8'($urandom);
      end
      bus.r_valid = v[0]; bus.r_in = d[0];
      bus.g_valid = v[1]; bus.g_in = d[1];
      bus.b_valid = v[2]; bus.b_in = d[2];
      tick();
      if (v[0] && rd[0]) begin er.push_back(d[0]); sent[0]++; end
      if (v[1] && rd[1]) begin eg.push_back(d[1]); sent[1]++; end
      if (v[2] && rd[2]) begin eb.push_back(d[2]); sent[2]++; end
    end
    idle_in();
    repeat (8) tick();
    bad = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      if (k >= er.size() || k >= eg.size() || k >= eb.size()) bad++;
      else if (got_q[k] !== {er[k], eg[k], eb[k]}) bad++;
    end
    check("rand_merges", mv_cnt, 1000);
    check("rand_order_errs", bad, 0);
    check("rand_no_tmo", bus.tmo_err, 0);
    check("rand_pix", bus.pix_cnt, 1000 % LINE_W);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
